// File: rtl/register_table.sv
// register_table: 128 x 128-bit dual-write, six-read register file with same-edge write bypass.
module register_table #(
  parameter int NUM_REGS = 128,
  parameter int WIDTH    = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:ADDR_W-1] ra_addr_even,
  input  logic [0:ADDR_W-1] rb_addr_even,
  input  logic [0:ADDR_W-1] rc_addr_even,
  input  logic [0:ADDR_W-1] ra_addr_odd,
  input  logic [0:ADDR_W-1] rb_addr_odd,
  input  logic [0:ADDR_W-1] rc_addr_odd,
  input  logic [0:WIDTH-1]  rt_wb_even,
  input  logic [0:ADDR_W-1] rt_addr_wb_even,
  input  logic              reg_write_wb_even,
  input  logic [0:WIDTH-1]  rt_wb_odd,
  input  logic [0:ADDR_W-1] rt_addr_wb_odd,
  input  logic              reg_write_wb_odd,
  output logic [0:WIDTH-1]  ra_even,
  output logic [0:WIDTH-1]  rb_even,
  output logic [0:WIDTH-1]  rc_even,
  output logic [0:WIDTH-1]  ra_odd,
  output logic [0:WIDTH-1]  rb_odd,
  output logic [0:WIDTH-1]  rc_odd
);
  logic [0:WIDTH-1]  r_mem [NUM_REGS];
  logic [0:WIDTH-1]  r_rd  [6];
  logic [0:ADDR_W-1] w_addr [6];
  logic [0:WIDTH-1]  w_rd  [6];
  assign w_addr[0] = ra_addr_even;
  assign w_addr[1] = rb_addr_even;
  assign w_addr[2] = rc_addr_even;
  assign w_addr[3] = ra_addr_odd;
  assign w_addr[4] = rb_addr_odd;
  assign w_addr[5] = rc_addr_odd;
  // odd is later in program order, so it takes priority on both bypass and storage
  for (genvar p = 0; p < 6; p++) begin : g_rd
    assign w_rd[p] = (reg_write_wb_odd  && w_addr[p] == rt_addr_wb_odd)  ? rt_wb_odd  :
                     (reg_write_wb_even && w_addr[p] == rt_addr_wb_even) ? rt_wb_even :
                     r_mem[w_addr[p]];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      for (int i = 0; i < 6; i++) r_rd[i] <= '0;
    end else begin
      if (reg_write_wb_even) r_mem[rt_addr_wb_even] <= rt_wb_even;
      if (reg_write_wb_odd)  r_mem[rt_addr_wb_odd]  <= rt_wb_odd;
      for (int i = 0; i < 6; i++) r_rd[i] <= w_rd[i];
    end
  end
  assign ra_even = r_rd[0];
  assign rb_even = r_rd[1];
  assign rc_even = r_rd[2];
  assign ra_odd  = r_rd[3];
  assign rb_odd  = r_rd[4];
  assign rc_odd  = r_rd[5];
endmodule

// File: tb/tb_register_table.sv
// tb_register_table: directed scoreboard bench for register_table.
module tb_register_table;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [0:6] ra_ae = '0, rb_ae = '0, rc_ae = '0, ra_ao = '0, rb_ao = '0, rc_ao = '0;
  logic [0:127] wd_e = '0, wd_o = '0;
  logic [0:6] wa_e = '0, wa_o = '0;
  logic we_e = 1'b0, we_o = 1'b0;
  logic [0:127] ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd;
  int errors = 0;
  int checks = 0;
  typedef struct { int port; logic [0:127] val; string tag; } exp_t;
  exp_t q[$];
  logic [0:127] model [128];

  always #5 clk = ~clk;

  register_table dut (
    .clk(clk), .reset(reset),
    .ra_addr_even(ra_ae), .rb_addr_even(rb_ae), .rc_addr_even(rc_ae),
    .ra_addr_odd(ra_ao), .rb_addr_odd(rb_ao), .rc_addr_odd(rc_ao),
    .rt_wb_even(wd_e), .rt_addr_wb_even(wa_e), .reg_write_wb_even(we_e),
    .rt_wb_odd(wd_o), .rt_addr_wb_odd(wa_o), .reg_write_wb_odd(we_o),
    .ra_even(ra_even), .rb_even(rb_even), .rc_even(rc_even),
    .ra_odd(ra_odd), .rb_odd(rb_odd), .rc_odd(rc_odd)
  );

  function automatic logic [0:127] port_val(input int p);
    case (p)
      0: return ra_even;
      1: return rb_even;
      2: return rc_even;
      3: return ra_odd;
      4: return rb_odd;
      default: return rc_odd;
    endcase
  endfunction

  task automatic check(input string tag, input int p, input logic [0:127] exp);
    logic [0:127] got;
    got = port_val(p);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s port%0d got=%h exp=%h", tag, p, got, exp);
    end
  endtask

  task automatic wr(input logic ee, input logic [0:6] ae, input logic [0:127] de,
                    input logic eo, input logic [0:6] ao, input logic [0:127] d_o);
    we_e = ee; wa_e = ae; wd_e = de;
    we_o = eo; wa_o = ao; wd_o = d_o;
  endtask

  task automatic rd(input logic [0:6] a0, input logic [0:6] a1, input logic [0:6] a2,
                    input logic [0:6] a3, input logic [0:6] a4, input logic [0:6] a5);
    ra_ae = a0; rb_ae = a1; rc_ae = a2; ra_ao = a3; rb_ao = a4; rc_ao = a5;
  endtask

  // Model commits even then odd, then reads; this yields bypass and odd-wins.
  task automatic step(input string tag);
    logic [0:6] a [6];
    exp_t e;
    a[0] = ra_ae; a[1] = rb_ae; a[2] = rc_ae; a[3] = ra_ao; a[4] = rb_ao; a[5] = rc_ao;
    if (we_e) model[wa_e] = wd_e;
    if (we_o) model[wa_o] = wd_o;
    for (int p = 0; p < 6; p++) begin
      e.port = p; e.val = model[a[p]]; e.tag = tag;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, e.port, e.val);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) model[i] = '0;
    #2;
    for (int p = 0; p < 6; p++) check("por", p, '0);
    @(negedge clk);
    reset = 1'b1;

    // async reset mid-operation
    wr(1, 5, '1, 0, 0, '0); rd(5, 5, 0, 0, 0, 0); step("wr_r5");
    wr(0, 0, '0, 0, 0, '0);
    #2 reset = 1'b0;
    #1;
    for (int p = 0; p < 6; p++) check("async_rst", p, '0);
    for (int i = 0; i < 128; i++) model[i] = '0;
    #1 reset = 1'b1;
    rd(5, 0, 0, 5, 0, 0); step("rst_r5");

    // basic write then read via odd port
    wr(1, 10, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 0, '0); rd(0, 0, 0, 0, 0, 0); step("wr_r10");
    wr(0, 0, '0, 0, 0, '0); rd(0, 0, 0, 10, 0, 0); step("rd_r10");

    // same-edge bypass
    wr(0, 0, '0, 1, 3, {16{8'hA5}}); rd(0, 3, 0, 0, 0, 3); step("bypass_r3");
    wr(0, 0, '0, 0, 0, '0); rd(3, 3, 3, 3, 3, 3); step("stored_r3");

    // dual-write conflict
    wr(1, 7, 128'd1, 1, 7, 128'd2); rd(7, 0, 0, 7, 0, 0); step("conflict_r7");
    wr(0, 0, '0, 0, 0, '0); rd(7, 7, 0, 0, 0, 7); step("conflict_rd_r7");

    // disabled write: no storage update, no bypass
    wr(1, 4, 128'h44, 0, 0, '0); rd(0, 0, 0, 0, 0, 0); step("wr_r4");
    wr(0, 4, {8{16'hDEAD}}, 0, 4, {8{16'hBEEF}}); rd(4, 4, 4, 4, 4, 4); step("dis_r4");
    wr(0, 0, '0, 0, 0, '0); rd(4, 0, 4, 0, 4, 0); step("dis_rd_r4");

    // full sweep r0..r127 = index
    for (int k = 0; k < 64; k++) begin
      wr(1, 7'(2 * k), 128'(2 * k), 1, 7'(2 * k + 1), 128'(2 * k + 1));
      rd(7'(2 * k), 7'(2 * k + 1), 0, 1, 7'(k), 127);
      step("sweep_wr");
    end
    wr(0, 0, '0, 0, 0, '0);
    for (int k = 0; k < 22; k++) begin
      rd(7'(6 * k), 7'(6 * k + 1), 7'(6 * k + 2), 7'(6 * k + 3), 7'(6 * k + 4), 7'(6 * k + 5));
      step("sweep_rd");
    end
    rd(0, 127, 1, 126, 64, 63); step("sweep_edges");
    check("r0", 0, 128'd0);
    check("r127", 1, 128'd127);

    // random traffic over a small address window to hit conflicts and bypasses
    for (int k = 0; k < 40; k++) begin
      wr(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
         1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
      rd(7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
         7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_table.md
# register_table

Architectural register file for the dual-issue SPU: 128 registers of 128 bits. It sits upstream of the even and odd execution pipes, including the permute unit, and downstream of their writeback outputs. Each cycle it accepts up to two writeback results, one per pipe, and registers three source operands per pipe for the RF/FWD stage. A same-edge write bypass means a result written on an edge is visible to a read sampled on that same edge.

## Interface
- NUM_REGS, 128, number of architectural registers
- WIDTH, 128, register width in bits, big-endian numbering [0:WIDTH-1]
- ADDR_W, 7, register address width, [0:ADDR_W-1]

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- ra_addr_even, rb_addr_even, rc_addr_even  input  ADDR_W  even-pipe source addresses
- ra_addr_odd, rb_addr_odd, rc_addr_odd  input  ADDR_W  odd-pipe source addresses
- rt_wb_even  input  WIDTH  even-pipe writeback data
- rt_addr_wb_even  input  ADDR_W  even-pipe writeback destination
- reg_write_wb_even  input  1  even-pipe write enable
- rt_wb_odd, rt_addr_wb_odd, reg_write_wb_odd  input  WIDTH/ADDR_W/1  odd-pipe writeback (permute/load/branch results)
- ra_even, rb_even, rc_even  output  WIDTH  registered even-pipe operands
- ra_odd, rb_odd, rc_odd  output  WIDTH  registered odd-pipe operands

## Operation
- Storage: NUM_REGS x WIDTH flops. All entries are writable, including register 0.
- Write: on a rising edge with reg_write_wb_X=1, mem[rt_addr_wb_X] <= rt_wb_X. With reg_write_wb_X=0, no write occurs and the address/data inputs are don't-care.
- Dual-write conflict: if both enables are high and the addresses are equal, the odd write wins. The odd instruction is later in program order within an issue pair.
- Read: on each rising edge, each of the six outputs <= value of its addressed register.
- Bypass: if a read address equals an enabled write address on the same edge, the output takes the incoming write data, not the stale entry.
  - If both pipes hit the same address, the output takes the odd data, consistent with the conflict rule.
  - Bypass applies independently to all six read ports.
- The read-port addresses are never checked against each other; duplicate read addresses are legal and return identical data.
- No stalls and no handshake. The block accepts writes and produces reads every cycle.

## Timing
- Read latency: 1 cycle. Addresses presented before edge N produce data valid after edge N and held until edge N+1.
- Write-to-read: a write sampled at edge N is returned by a read sampled at edge N (via bypass) or at any later edge (via storage).
- Reset (reset=0, asynchronous): all NUM_REGS entries and all six outputs clear to 0 immediately, with no clock required. They stay 0 while reset is low.
- Reset deassertion: the first write and read sampling happens at the first rising edge with reset=1.
- Reset mid-operation: any write coincident with the asserting edge is lost. Outputs show 0 on the first read after release unless bypass supplies new data.
- No X propagation from unused write data when reg_write_wb_X=0.

## Test plan
- Reset: write 0xFFFF...F to r5, then pulse reset low between edges. Required: ra_even goes to 0 asynchronously, and reading r5 after release returns 0.
- Basic write/read: write r10 = 0x0123...CDEF via the even pipe at edge 1. Present ra_addr_odd=10 at edge 2. Required: ra_odd = 0x0123...CDEF after edge 2.
- Same-edge bypass: at edge 1 the odd pipe writes r3 = 0xA5A5...A5 while rb_addr_even=3 and rc_addr_odd=3. Required: rb_even = rc_odd = 0xA5A5...A5 after edge 1.
- Dual-write conflict: at the same edge, even writes r7 = 1 and odd writes r7 = 2, with ra_addr_even=7. Required: ra_even=2 after that edge, and r7 reads 2 on the next cycle.
- Disabled write: reg_write_wb_even=0, rt_addr_wb_even=4, rt_wb_even=0xDEAD... Required: r4 retains its previous value, and there is no bypass on a port reading r4.
- Full sweep: write r0..r127 with value = index, then read all six ports with distinct addresses. Required: each port returns its address value. Check r0 and r127 explicitly.
